// File: rtl/text_pkg.sv
// Shared constants and writer state encoding for the character-cell text display.
package text_pkg;

  localparam logic [4:0] BLANK_CODE = 5'd26;

  localparam int TEXT_COLS  = 32;
  localparam int TEXT_ROWS  = 16;
  localparam int TEXT_CELLS = TEXT_COLS * TEXT_ROWS;

  localparam logic [7:0] ASCII_NL = 8'h0A;
  localparam logic [7:0] ASCII_FF = 8'h0C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAD   = 2'd1,
    CLEAR = 2'd2
  } writer_state_t;

endpackage

// File: rtl/text_stream_writer_if.sv
// Byte stream in, display write port and status out; master is upstream, slave is the writer.
interface text_stream_writer_if;

  logic       ascii_valid_in;
  logic [7:0] ascii_in;
  logic       ascii_ready_out;
  logic       data_valid_out;
  logic [4:0] data_out;
  logic [8:0] cursor_out;
  logic       busy_out;
  logic       drop_out;

  modport master (
    output ascii_valid_in, ascii_in,
    input  ascii_ready_out, data_valid_out, data_out, cursor_out, busy_out, drop_out
  );

  modport slave (
    input  ascii_valid_in, ascii_in,
    output ascii_ready_out, data_valid_out, data_out, cursor_out, busy_out, drop_out
  );

endinterface

// File: rtl/ascii_to_letter.sv
// Combinational ASCII classifier: letters (either case) to 0-25, space to blank, flags NL/FF.
module ascii_to_letter
  import text_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [4:0] code,
  output logic       is_print,
  output logic       is_nl,
  output logic       is_ff
);

  always_comb begin
    code     = BLANK_CODE;
    is_print = 1'b0;
    if (ascii >= 8'h41 && ascii <= 8'h5A) begin
      code     = 5'(ascii - 8'h41);
      is_print = 1'b1;
    end else if (ascii >= 8'h61 && ascii <= 8'h7A) begin
      code     = 5'(ascii - 8'h61);
      is_print = 1'b1;
    end else if (ascii == 8'h20) begin
      is_print = 1'b1;
    end
  end

  assign is_nl = (ascii == ASCII_NL);
  assign is_ff = (ascii == ASCII_FF);

endmodule

// File: rtl/text_stream_writer.sv
// Byte stream to display cells, one cell/cycle, outputs registered; ready only in IDLE.
// TEXT_NEWLINE_PAD_EN builds the newline-to-end-of-row padding; otherwise newline is dropped.
module text_stream_writer
  import text_pkg::*;
#(
  parameter int COLS  = TEXT_COLS,
  parameter int CELLS = TEXT_CELLS
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  text_stream_writer_if.slave bus
);

  writer_state_t state_q, state_d;
  logic [10:0]   rem_q, rem_d;
  logic          vld_q, vld_d;
  logic [4:0]    dat_q, dat_d;
  logic [8:0]    cur_q, cur_d;
  logic          drop_q, drop_d;

  logic [4:0]    code;
  logic          is_print;
  logic          is_nl;
  logic          is_ff;

  logic [8:0]    cur_inc;
  logic [10:0]   clr_len;

  ascii_to_letter u_map (
    .ascii    (bus.ascii_in),
    .code     (code),
    .is_print (is_print),
    .is_nl    (is_nl),
    .is_ff    (is_ff)
  );

  // Cursor wraps exactly like the display's own write counter.
  assign cur_inc = 9'((int'(cur_q) + 1) % CELLS);
  assign clr_len = 11'(CELLS + ((CELLS - int'(cur_q)) % CELLS));

`ifdef TEXT_NEWLINE_PAD_EN
  logic [10:0] pad_len;
  assign pad_len = 11'(COLS - (int'(cur_q) % COLS));
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      rem_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= BLANK_CODE;
      cur_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      cur_q   <= cur_d;
      drop_q  <= drop_d;
    end
  end

  // rem_q counts the blanks of the run still to appear on the display, including
  // the one currently presented; the run ends in the cycle it reaches one.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    vld_d   = 1'b0;
    dat_d   = dat_q;
    cur_d   = cur_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ascii_valid_in) begin
          if (is_print) begin
            vld_d = 1'b1;
            dat_d = code;
            cur_d = cur_inc;
          end else if (is_ff) begin
            state_d = CLEAR;
            rem_d   = clr_len;
            vld_d   = 1'b1;
            dat_d   = BLANK_CODE;
            cur_d   = cur_inc;
          end
`ifdef TEXT_NEWLINE_PAD_EN
          else if (is_nl) begin
            state_d = PAD;
            rem_d   = pad_len;
            vld_d   = 1'b1;
            dat_d   = BLANK_CODE;
            cur_d   = cur_inc;
          end
`else
          else if (is_nl) begin
            drop_d = 1'b1;
          end
`endif
          else begin
            drop_d = 1'b1;
          end
        end
      end
`ifdef TEXT_NEWLINE_PAD_EN
      PAD, CLEAR: begin
`else
      CLEAR: begin
`endif
        if (rem_q == 11'd1) begin
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - 11'd1;
          vld_d = 1'b1;
          dat_d = BLANK_CODE;
          cur_d = cur_inc;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  assign bus.ascii_ready_out = (state_q == IDLE);
  assign bus.busy_out        = (state_q != IDLE);
  assign bus.data_valid_out  = vld_q;
  assign bus.data_out        = dat_q;
  assign bus.cursor_out      = cur_q;
  assign bus.drop_out        = drop_q;

endmodule

// File: tb/tb_text_stream_writer.sv
// Scoreboard bench for text_stream_writer: expected cells queued on accept, checked on data_valid_out.
module tb_text_stream_writer;

  typedef struct packed {
    logic [4:0] code;
    logic [8:0] cursor;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  text_stream_writer_if bus ();

  text_stream_writer #(.COLS(32), .CELLS(512)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  int   total = 0;
  int   bad   = 0;
  int   cur   = 0;
  int   drops = 0;
  int   exp_drops = 0;
  int   cells = 0;
  int   cyc   = 0;
  int   cell_cyc[$];
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_code(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) return int'(b) - 65;
    if (b >= 8'h61 && b <= 8'h7A) return int'(b) - 97;
    if (b == 8'h20) return 26;
    return -1;
  endfunction

  task automatic push_blanks(input int k);
    exp_t e;
    for (int i = 0; i < k; i++) begin
      cur = (cur + 1) % 512;
      e.code = 5'd26;
      e.cursor = 9'(cur);
      sbq.push_back(e);
    end
  endtask

  task automatic model(input logic [7:0] b);
    exp_t e;
    int   c;
    c = exp_code(b);
    if (c >= 0) begin
      cur = (cur + 1) % 512;
      e.code = 5'(c);
      e.cursor = 9'(cur);
      sbq.push_back(e);
    end else if (b == 8'h0C) begin
      push_blanks(512 + (512 - cur) % 512);
`ifdef TEXT_NEWLINE_PAD_EN
    end else if (b == 8'h0A) begin
      push_blanks(32 - cur % 32);
`endif
    end else begin
      exp_drops++;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    bus.ascii_valid_in = 1'b1;
    bus.ascii_in = b;
    n = 0;
    while (!bus.ascii_ready_out && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ascii_ready_out) begin
      chk("ready_timeout", 0, 1);
      bus.ascii_valid_in = 1'b0;
    end else begin
      @(posedge clk);
      model(b);
      #1 bus.ascii_valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
    @(negedge clk);
    chk("idle_ready", bus.ascii_ready_out, 1);
    chk("idle_busy", bus.busy_out, 0);
  endtask

  task automatic run_shape(input string tag, input int k);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, bus.busy_out, 1);
      chk({tag, "_notready"}, bus.ascii_ready_out, 0);
      chk({tag, "_vld"}, bus.data_valid_out, 1);
    end
    @(negedge clk);
    chk({tag, "_ready_after"}, bus.ascii_ready_out, 1);
    chk({tag, "_vld_after"}, bus.data_valid_out, 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_vld"}, bus.data_valid_out, 0);
    chk({tag, "_data"}, bus.data_out, 26);
    chk({tag, "_cursor"}, bus.cursor_out, 0);
    chk({tag, "_drop"}, bus.drop_out, 0);
    chk({tag, "_busy"}, bus.busy_out, 0);
    chk({tag, "_ready"}, bus.ascii_ready_out, 1);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.drop_out) drops++;
      if (bus.data_valid_out) begin
        exp_t e;
        cells++;
        cell_cyc.push_back(cyc);
        if (sbq.size() == 0) begin
          chk("unexpected_cell", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("cell_code", bus.data_out, e.code);
          chk("cell_cursor", bus.cursor_out, e.cursor);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int d0;
    string hiz;
    rst_n = 1'b1;
    bus.ascii_valid_in = 1'b0;
    bus.ascii_in = 8'h00;
    #2 rst_n = 1'b0;
    #1 chk_reset_values("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // "Hi z" back to back
    hiz = "Hi z";
    cell_cyc.delete();
    for (int i = 0; i < 4; i++) send(hiz[i]);
    drain();
    chk("hiz_cells", cell_cyc.size(), 4);
    if (cell_cyc.size() == 4) chk("hiz_consecutive", cell_cyc[3] - cell_cyc[0], 3);
    chk("hiz_cursor", bus.cursor_out, 4);

    send("a");
    drain();
    chk("cursor5", bus.cursor_out, 5);

`ifdef TEXT_NEWLINE_PAD_EN
    c0 = cells;
    send(8'h0A);
    run_shape("nl27", 27);
    drain();
    chk("nl27_len", cells - c0, 27);
    chk("nl27_cursor", bus.cursor_out, 32);
    c0 = cells;
    send(8'h0A);
    run_shape("nl32", 32);
    drain();
    chk("nl32_len", cells - c0, 32);
    chk("nl32_cursor", bus.cursor_out, 64);
`else
    c0 = cells;
    d0 = drops;
    send(8'h0A);
    repeat (2) @(negedge clk);
    chk("nl_drop", drops - d0, 1);
    chk("nl_no_cell", cells - c0, 0);
    chk("nl_cursor", bus.cursor_out, 5);
`endif

    // clear from wherever the cursor is, then from 0 and from 100
    send(8'h0C);
    @(negedge clk);
    chk("ff_busy", bus.busy_out, 1);
    drain();
    chk("ff_cursor", bus.cursor_out, 0);

    c0 = cells;
    send(8'h0C);
    run_shape("ff0", 512);
    drain();
    chk("ff0_len", cells - c0, 512);
    chk("ff0_cursor", bus.cursor_out, 0);

    for (int i = 0; i < 100; i++) send("x");
    drain();
    chk("cursor100", bus.cursor_out, 100);
    c0 = cells;
    send(8'h0C);
    drain();
    chk("ff100_len", cells - c0, 924);
    chk("ff100_cursor", bus.cursor_out, 0);

    for (int i = 0; i < 511; i++) send("m");
    drain();
    chk("cursor511", bus.cursor_out, 511);
    send("A");
    drain();
    chk("wrap_cursor", bus.cursor_out, 0);

    c0 = cells;
    d0 = drops;
    send(8'h31);
    repeat (2) @(negedge clk);
    chk("drop_pulse", drops - d0, 1);
    chk("drop_no_cell", cells - c0, 0);
    chk("drop_cursor", bus.cursor_out, 0);

    // reset in the middle of a clear run
    send(8'h0C);
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_values("midrst");
    sbq.delete();
    cur = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send("B");
    drain();
    chk("post_rst_cursor", bus.cursor_out, 1);

    chk("drop_total", drops, exp_drops);
    chk("sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/text_stream_writer.md
# text_stream_writer

Producer side of the character-cell text display's write port. Accepts ASCII bytes over a valid/ready handshake and converts them to the display's 5-bit letter codes: 0–25 for A–Z, 26 for blank. It drives the display's `data_valid_in`/`data_in` pair at up to one cell per cycle and expands newline and form-feed into runs of blank cells. It keeps a cursor that mirrors the display's internal 0..511 write counter, so line and screen control needs no read-back.

## Interface
Parameters:
- `COLS`, 32, cells per row; must be a power of two.
- `CELLS`, 512, total cells; must be a power of two; the cursor wraps at `CELLS-1`.

Ports:
- `clk_in`  in  1  system clock; must be the same clock as the display's write port.
- `rst_n_in`  in  1  asynchronous active-low reset.
- `ascii_valid_in`  in  1  upstream byte valid.
- `ascii_in`  in  8  upstream byte.
- `ascii_ready_out`  out  1  byte accepted when high together with `ascii_valid_in`.
- `data_valid_out`  out  1  connects to the display's `data_valid_in`.
- `data_out`  out  5  connects to the display's `data_in`.
- `cursor_out`  out  9  index of the next cell to be written.
- `busy_out`  out  1  high while a pad or clear run is in progress.
- `drop_out`  out  1  one-cycle pulse when an accepted byte produces no output.

## Operation
- States: IDLE, PAD, CLEAR.
- `ascii_ready_out` is high only in IDLE.
- Byte mapping:
  - 0x41–0x5A maps to byte−0x41.
  - 0x61–0x7A maps to byte−0x61.
  - 0x20 maps to 26.
  - Each of these is a printable byte: emit one cell, then cursor+1.
- 0x0A (newline): go to PAD. Remaining count = `COLS − (cursor mod COLS)`, so a newline at column 0 emits a full blank row.
- 0x0C (form feed): go to CLEAR. Remaining count = `CELLS + ((CELLS − cursor) mod CELLS)`. This blanks every cell and leaves the cursor at 0.
- Any other byte: accepted, no cell emitted, `drop_out` pulses, cursor unchanged.
- PAD and CLEAR: emit code 26 every cycle and decrement the remaining count. The state that emits the last blank goes back to IDLE.
- Cursor arithmetic:
  - 9-bit, incremented on every emitted cell.
  - Wraps 511→0 with no flag, the same as the display counter.
  - The remaining counter is 11 bits wide (maximum 1023).
- `data_out` holds its last value when `data_valid_out` is low.

## Timing
- All outputs are registered except `ascii_ready_out` and `busy_out`, which decode state directly.
- Reset values:
  - State IDLE.
  - `data_valid_out` 0, `data_out` 26.
  - `cursor_out` 0, `drop_out` 0.
  - `busy_out` 0, `ascii_ready_out` 1.
- Printable byte accepted at cycle N: `data_valid_out` is high at N+1. Back-to-back printable bytes sustain one cell per cycle.
- Newline accepted at N with k blanks to emit:
  - `data_valid_out` high N+1..N+k.
  - `busy_out` and not-ready N+1..N+k.
  - Ready again at N+k+1.
- CLEAR has the same shape as PAD, with k from the formula in Operation.
- A reset asserted mid-run aborts immediately: IDLE, cursor 0. The display must be reset in the same cycle window so the two counters stay aligned.

## Configuration
- `TEXT_NEWLINE_PAD_EN` defined: newline behaves as described above.
- Not defined: 0x0A is treated as an unmapped byte (drop pulse) and the PAD state is not synthesised. Form feed is unaffected.

## Structure
- Shared package `text_pkg` holds:
  - `BLANK_CODE` = 26, `TEXT_COLS` = 32, `TEXT_ROWS` = 16, `TEXT_CELLS` = 512.
  - `ASCII_NL` = 8'h0A, `ASCII_FF` = 8'h0C.
  - The state enum `writer_state_t`.
- Sub-module `ascii_to_letter`: purely combinational. Byte in; 5-bit code, `is_print`, `is_nl`, `is_ff` out.

## Test plan
- Reset, then send "Hi z" at one byte per cycle → codes 7, 8, 26, 25 on four consecutive cycles; cursor reaches 4.
- Cursor 5, send 0x0A → 27 blanks on cycles N+1..N+27, ready low for those cycles, cursor 32. A second 0x0A at cursor 32 → 32 blanks.
- Cursor 0, send 0x0C → 512 blanks, cursor 0. Cursor 100 → 924 blanks, cursor 0.
- Cursor 511, send "A" → code 0 emitted, cursor wraps to 0.
- Send 0x31 ("1") → `drop_out` pulses once, `data_valid_out` stays low, cursor unchanged.
- Assert `rst_n_in` low in the middle of a CLEAR run → outputs immediately take their reset values; after release, "B" → code 1 with cursor going 0→1.
